// File: rtl/count_pkg.sv
// Shared types for the modulo up/down counter: boundary modes and one-shot FSM states.
package count_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP,
    CNT_SAT,
    CNT_ONESHOT
  } cnt_mode_e;

  typedef enum logic {
    RUN,
    HALT
  } cnt_state_e;

endpackage

// File: rtl/count_step_arith.sv
// Combinational step arithmetic: next count and boundary-hit flag for one enabled cycle.
module count_step_arith
  import count_pkg::*;
#(
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned MAX_VAL = 1595,
  parameter int unsigned STEP_W  = 4,
  parameter cnt_mode_e   MODE    = CNT_WRAP
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic [STEP_W-1:0] step,
  input  logic              updn,
  output logic [WIDTH-1:0]  nxt,
  output logic              hit
);

  localparam int unsigned XW = WIDTH + 1;
  localparam logic [WIDTH:0] MaxX = XW'(MAX_VAL);
  localparam logic [WIDTH:0] ModX = XW'(MAX_VAL + 1);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] nxt_x;

  assign cnt_x  = {1'b0, cnt};
  assign step_x = XW'(step);
  assign sum    = cnt_x + step_x;
  assign diff   = cnt_x - step_x;

  always_comb begin
    nxt_x = cnt_x;
    hit   = 1'b0;
    if (!updn) begin
      if (MODE == CNT_WRAP) begin
        if (sum > MaxX) begin
          nxt_x = sum - ModX;
          hit   = 1'b1;
        end else begin
          nxt_x = sum;
        end
      end else if (sum >= MaxX) begin
        // SAT only flags the first arrival; ONESHOT flags every hit
        nxt_x = MaxX;
        hit   = (MODE == CNT_ONESHOT) || (cnt_x != MaxX);
      end else begin
        nxt_x = sum;
      end
    end else begin
      if (MODE == CNT_WRAP) begin
        if (step_x > cnt_x) begin
          nxt_x = cnt_x + ModX - step_x;
          hit   = 1'b1;
        end else begin
          nxt_x = diff;
        end
      end else if (step_x >= cnt_x) begin
        nxt_x = '0;
        hit   = (MODE == CNT_ONESHOT) || (cnt_x != '0);
      end else begin
        nxt_x = diff;
      end
    end
  end

  assign nxt = nxt_x[WIDTH-1:0];

endmodule

// File: rtl/count_mod_updn.sv
// Loadable modulo up/down counter with variable step, clear, and wrap/saturate/one-shot modes.
module count_mod_updn
  import count_pkg::*;
#(
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned MAX_VAL = 1595,
  parameter int unsigned STEP_W  = 4,
  parameter cnt_mode_e   MODE    = CNT_WRAP
) (
  input  logic              clk5m,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic              updn,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  cnt,
  output logic              tc,
  output logic              halted
);

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  cnt_state_e       state_q, state_d;

  logic [WIDTH-1:0] arith_nxt;
  logic             arith_hit;

  count_step_arith #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL),
    .STEP_W (STEP_W),
    .MODE   (MODE)
  ) u_arith (
    .cnt (cnt_q),
    .step(step),
    .updn(updn),
    .nxt (arith_nxt),
    .hit (arith_hit)
  );

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    state_d = state_q;
    if (clr) begin
      cnt_d   = '0;
      state_d = RUN;
    end else if (load) begin
      cnt_d   = (data_in > MaxCnt) ? MaxCnt : data_in;
      state_d = RUN;
    end else if (en && (step != '0) && (state_q != HALT)) begin
      cnt_d = arith_nxt;
      tc_d  = arith_hit;
      if ((MODE == CNT_ONESHOT) && arith_hit) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      state_q <= RUN;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign cnt    = cnt_q;
  assign tc     = tc_q;
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_count_mod_updn.sv
// Bench for count_mod_updn: directed vector table per mode plus randomized model comparison.
module tb_count_mod_updn;
  import count_pkg::*;

  localparam int W    = 11;
  localparam int MAXV = 1595;
  localparam int SW   = 4;

  logic          clk5m;
  logic          rst_n;
  logic          clr, en, load, updn;
  logic [SW-1:0] step;
  logic [W-1:0]  data_in;
  logic [W-1:0]  cnt_o    [3];
  logic          tc_o     [3];
  logic          halted_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt  [3];
  bit m_tc   [3];
  bit m_halt [3];

  typedef struct {
    int mode;
    bit clr;
    bit load;
    bit en;
    bit updn;
    int step;
    int data;
    int cnt;
    bit tc;
    bit halted;
  } vec_t;

  vec_t vecs[$];

  count_mod_updn #(.WIDTH(W), .MAX_VAL(MAXV), .STEP_W(SW), .MODE(CNT_WRAP)) u_wrap (
    .clk5m(clk5m), .rst_n(rst_n), .clr(clr), .en(en), .load(load), .updn(updn),
    .step(step), .data_in(data_in), .cnt(cnt_o[0]), .tc(tc_o[0]), .halted(halted_o[0])
  );

  count_mod_updn #(.WIDTH(W), .MAX_VAL(MAXV), .STEP_W(SW), .MODE(CNT_SAT)) u_sat (
    .clk5m(clk5m), .rst_n(rst_n), .clr(clr), .en(en), .load(load), .updn(updn),
    .step(step), .data_in(data_in), .cnt(cnt_o[1]), .tc(tc_o[1]), .halted(halted_o[1])
  );

  count_mod_updn #(.WIDTH(W), .MAX_VAL(MAXV), .STEP_W(SW), .MODE(CNT_ONESHOT)) u_one (
    .clk5m(clk5m), .rst_n(rst_n), .clr(clr), .en(en), .load(load), .updn(updn),
    .step(step), .data_in(data_in), .cnt(cnt_o[2]), .tc(tc_o[2]), .halted(halted_o[2])
  );

  initial begin
    clk5m = 1'b0;
    forever #5 clk5m = ~clk5m;
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic v(input int mode, input bit c, input bit l, input bit e, input bit u,
                   input int s, input int d, input int ec, input bit et, input bit eh);
    vec_t r;
    r.mode = mode; r.clr = c; r.load = l; r.en = e; r.updn = u;
    r.step = s; r.data = d; r.cnt = ec; r.tc = et; r.halted = eh;
    vecs.push_back(r);
  endtask

  task automatic drive(input bit c, input bit l, input bit e, input bit u, input int s,
                       input int d);
    clr = c; load = l; en = e; updn = u;
    step = SW'(s);
    data_in = W'(d);
  endtask

  // Reference: plain integer arithmetic over the range 0..MAXV
  task automatic model_tick(input int m);
    int c, t, bound;
    bit t_c, h;
    c   = m_cnt[m];
    h   = m_halt[m];
    t_c = 1'b0;
    if (clr) begin
      c = 0;
      h = 1'b0;
    end else if (load) begin
      c = (int'(data_in) > MAXV) ? MAXV : int'(data_in);
      h = 1'b0;
    end else if (en && step != 0 && !h) begin
      t = updn ? c - int'(step) : c + int'(step);
      if (m == 0) begin
        if (t > MAXV) begin
          t   = t - (MAXV + 1);
          t_c = 1'b1;
        end else if (t < 0) begin
          t   = t + (MAXV + 1);
          t_c = 1'b1;
        end
      end else if (t >= MAXV || t <= 0) begin
        bound = (t >= MAXV) ? MAXV : 0;
        t_c   = (m == 2) || (c != bound);
        t     = bound;
        if (m == 2) h = 1'b1;
      end
      c = t;
    end
    m_cnt[m]  = c;
    m_tc[m]   = t_c;
    m_halt[m] = h;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Wrap mode
    v(0, 0, 1, 0, 0, 0, 1590, 1590, 0, 0);
    v(0, 0, 0, 1, 0, 4, 0, 1594, 0, 0);
    v(0, 0, 0, 1, 0, 4, 0, 2, 1, 0);
    v(0, 0, 0, 1, 0, 4, 0, 6, 0, 0);
    v(0, 0, 1, 0, 0, 0, 2, 2, 0, 0);
    v(0, 0, 0, 1, 1, 5, 0, 1593, 1, 0);
    v(0, 0, 0, 1, 1, 5, 0, 1588, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1591, 1591, 0, 0);
    v(0, 0, 0, 1, 0, 4, 0, 1595, 0, 0);
    v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    // Saturate mode
    v(1, 0, 1, 0, 0, 0, 1593, 1593, 0, 0);
    v(1, 0, 0, 1, 0, 2, 0, 1595, 1, 0);
    v(1, 0, 0, 1, 0, 2, 0, 1595, 0, 0);
    v(1, 0, 0, 1, 1, 2, 0, 1593, 0, 0);
    v(1, 0, 1, 0, 0, 0, 4, 4, 0, 0);
    v(1, 0, 0, 1, 1, 4, 0, 0, 1, 0);
    v(1, 0, 0, 1, 1, 4, 0, 0, 0, 0);
    v(1, 0, 1, 0, 0, 0, 2, 2, 0, 0);
    v(1, 0, 0, 1, 1, 5, 0, 0, 1, 0);
    // One-shot mode
    v(2, 0, 1, 0, 0, 0, 3, 3, 0, 0);
    v(2, 0, 0, 1, 1, 3, 0, 0, 1, 1);
    v(2, 0, 0, 1, 1, 3, 0, 0, 0, 1);
    v(2, 0, 0, 1, 0, 5, 0, 0, 0, 1);
    v(2, 0, 1, 0, 0, 0, 10, 10, 0, 0);
    v(2, 0, 0, 1, 1, 3, 0, 7, 0, 0);
    v(2, 0, 1, 0, 0, 0, 1590, 1590, 0, 0);
    v(2, 0, 0, 1, 0, 8, 0, 1595, 1, 1);
    v(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load clamp and priorities
    v(0, 0, 1, 0, 0, 0, 1023, 1023, 0, 0);
    v(0, 0, 1, 0, 0, 0, 2047, 1595, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1596, 1595, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1595, 1595, 0, 0);
    v(0, 0, 1, 1, 0, 3, 5, 5, 0, 0);
    v(0, 0, 0, 1, 0, 0, 0, 5, 0, 0);
    v(0, 1, 1, 0, 0, 0, 100, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 50, 50, 0, 0);
    v(0, 1, 0, 1, 0, 7, 0, 0, 0, 0);

    @(negedge clk5m);
    for (int m = 0; m < 3; m++) begin
      check("reset_cnt", m, int'(cnt_o[m]), 0);
      check("reset_tc", m, int'(tc_o[m]), 0);
      check("reset_halted", m, int'(halted_o[m]), 0);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].updn, vecs[i].step, vecs[i].data);
      @(posedge clk5m);
      @(negedge clk5m);
      check("vec_cnt", i, int'(cnt_o[vecs[i].mode]), vecs[i].cnt);
      check("vec_tc", i, int'(tc_o[vecs[i].mode]), int'(vecs[i].tc));
      check("vec_halted", i, int'(halted_o[vecs[i].mode]), int'(vecs[i].halted));
    end

    // Asynchronous reset between edges, mid-count, with the one-shot halted
    drive(0, 1, 0, 0, 0, 30);
    @(posedge clk5m);
    @(negedge clk5m);
    drive(0, 0, 1, 0, 7, 0);
    @(posedge clk5m);
    @(negedge clk5m);
    check("count_to_37", 0, int'(cnt_o[0]), 37);
    drive(0, 1, 0, 0, 0, 1);
    @(posedge clk5m);
    @(negedge clk5m);
    drive(0, 0, 1, 1, 4, 0);
    @(posedge clk5m);
    @(negedge clk5m);
    check("pre_reset_halted", 2, int'(halted_o[2]), 1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      check("async_rst_cnt", m, int'(cnt_o[m]), 0);
      check("async_rst_tc", m, int'(tc_o[m]), 0);
      check("async_rst_halted", m, int'(halted_o[m]), 0);
    end
    #1 rst_n = 1'b1;

    // Randomized comparison against the reference model
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk5m);
    @(negedge clk5m);
    for (int m = 0; m < 3; m++) begin
      m_cnt[m] = 0; m_tc[m] = 1'b0; m_halt[m] = 1'b0;
    end
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) < 3),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 2047)));
      @(posedge clk5m);
      for (int m = 0; m < 3; m++) model_tick(m);
      @(negedge clk5m);
      for (int m = 0; m < 3; m++) begin
        check("rand_cnt", m, int'(cnt_o[m]), m_cnt[m]);
        check("rand_tc", m, int'(tc_o[m]), int'(m_tc[m]));
        check("rand_halted", m, int'(halted_o[m]), int'(m_halt[m]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
